// File: rtl/spi_pkg.sv
// Shared constants, FSM encoding and frame packing for the SPI initiator that
// talks to the on-chip PWM register-file peripheral.
package spi_pkg;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_W     = 7;
   localparam int DATA_W     = 8;

   localparam logic              RW_WRITE = 1'b1;
   localparam logic [ADDR_W-1:0] MAX_ADDR = 7'd8;

   localparam logic [ADDR_W-1:0] ADDR_EN_OUT   = 7'd0;
   localparam logic [ADDR_W-1:0] ADDR_POLARITY = 7'd1;
   localparam logic [ADDR_W-1:0] ADDR_DUTY0    = 7'd2;
   localparam logic [ADDR_W-1:0] ADDR_DUTY1    = 7'd3;
   localparam logic [ADDR_W-1:0] ADDR_DUTY2    = 7'd4;
   localparam logic [ADDR_W-1:0] ADDR_DUTY3    = 7'd5;
   localparam logic [ADDR_W-1:0] ADDR_DUTY4    = 7'd6;
   localparam logic [ADDR_W-1:0] ADDR_DUTY5    = 7'd7;
   localparam logic [ADDR_W-1:0] ADDR_PWM_DIV  = 7'd8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_HOLD  = 3'd4,
      ST_GAP   = 3'd5
   } state_e;

   function automatic logic [FRAME_BITS-1:0] pack_frame(input logic              rw,
                                                        input logic [ADDR_W-1:0] addr,
                                                        input logic [DATA_W-1:0] data);
      return {rw, addr, data};
   endfunction

endpackage

// File: rtl/spi_sclk_timer.sv
// Loadable down-counter that flags the last cycle of an SCLK phase or CS gap.
module spi_sclk_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// Mode-0, MSB-first SPI initiator: one 16-bit {R/W, addr, wdata} frame per
// accepted request, returning the byte shifted in on CIPO during the data phase.
module spi_controller
   import spi_pkg::*;
#(
   parameter int HALF_PERIOD = 4,
   parameter int CS_GAP      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              nCS,
   output logic              SCLK,
   output logic              COPI,
   input  logic              CIPO
);

   localparam int PH_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(HALF_PERIOD - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CS_GAP - 1);
   localparam logic [4:0]       LAST_BIT = 5'(FRAME_BITS - 1);
   localparam logic [4:0]       RX_FIRST = 5'(FRAME_BITS - DATA_W);

   // Peripheral needs a 2-flop sync plus edge detect per phase, and time to commit between frames.
   if (HALF_PERIOD < 4) begin : g_chk_half_period
      $error("spi_controller: HALF_PERIOD must be >= 4");
   end
   if (CS_GAP < 4) begin : g_chk_cs_gap
      $error("spi_controller: CS_GAP must be >= 4");
   end

   state_e                  state_q, state_d;
   logic [4:0]              bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]       rx_q, rx_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    cipo_meta_q, cipo_sync_q;
   logic                    accept, phase_done, gap_done, ph_load, gap_load;
   logic                    high_end, last_bit;

   assign accept   = req_valid && (state_q == ST_IDLE);
   assign high_end = (state_q == ST_HIGH) && phase_done;
   assign last_bit = (bit_cnt_q == LAST_BIT);
   assign ph_load  = accept || (phase_done && ((state_q == ST_SETUP) ||
                                               (state_q == ST_HIGH)  ||
                                               (state_q == ST_LOW)));
   assign gap_load = phase_done && (state_q == ST_HOLD);

   spi_sclk_timer #(.CNT_W(PH_W)) u_phase_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (ph_load),
      .load_val_i (PH_LOAD),
      .done_o     (phase_done)
   );

   spi_sclk_timer #(.CNT_W(GAP_W)) u_gap_tmr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (gap_load),
      .load_val_i (GAP_LOAD),
      .done_o     (gap_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         rdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         cipo_meta_q <= 1'b0;
         cipo_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         cipo_meta_q <= CIPO;
         cipo_sync_q <= cipo_meta_q;
      end
   end

   // Shift registers carry no reset: COPI is gated by nCS and rx is refilled every frame.
   always_ff @(posedge clk) begin
      tx_q <= tx_d;
      rx_q <= rx_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept)     state_d = ST_SETUP;
         ST_SETUP: if (phase_done) state_d = ST_HIGH;
         ST_HIGH:  if (phase_done) state_d = last_bit ? ST_HOLD : ST_LOW;
         ST_LOW:   if (phase_done) state_d = ST_HIGH;
         ST_HOLD:  if (phase_done) state_d = ST_GAP;
         ST_GAP:   if (gap_done)   state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_d        = tx_q;
      rx_d        = rx_q;
      bit_cnt_d   = bit_cnt_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      if (accept) begin
         tx_d      = pack_frame(req_write, req_addr, req_wdata);
         bit_cnt_d = '0;
      end
      if (high_end) begin
         bit_cnt_d = bit_cnt_q + 5'd1;
         if (!last_bit) tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
         if (bit_cnt_q >= RX_FIRST) rx_d = {rx_q[DATA_W-2:0], cipo_sync_q};
      end
      if (gap_load) begin
         rdata_d     = rx_q;
         rsp_valid_d = 1'b1;
      end
   end

   always_comb begin
      nCS       = 1'b1;
      SCLK      = 1'b0;
      COPI      = 1'b0;
      req_ready = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_SETUP, ST_LOW, ST_HOLD: begin
            nCS  = 1'b0;
            COPI = tx_q[FRAME_BITS-1];
         end
         ST_HIGH: begin
            nCS  = 1'b0;
            SCLK = 1'b1;
            COPI = tx_q[FRAME_BITS-1];
         end
         default: ;
      endcase
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a behavioural register-file peripheral on the SPI
// pins plus timing counters around each host request.
module tb_spi_controller;
   import spi_pkg::*;

   localparam int HP        = 4;
   localparam int HP7       = 7;
   localparam int GAP       = 8;
   localparam int FRAME_CYC = 33 * HP;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n     = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_write = 1'b0;
   logic [6:0] req_addr  = '0;
   logic [7:0] req_wdata = '0;
   logic       req_ready, rsp_valid, busy, nCS, SCLK, COPI;
   logic [7:0] rsp_rdata;
   logic       CIPO = 1'b0;

   spi_controller #(.HALF_PERIOD(HP), .CS_GAP(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .nCS(nCS), .SCLK(SCLK), .COPI(COPI), .CIPO(CIPO)
   );

   logic       r7_valid = 1'b0;
   logic       r7_ready, r7_rsp_valid, r7_busy, r7_ncs, r7_sclk, r7_copi;
   logic [7:0] r7_rdata;
   logic [15:0] f7 = '0;

   spi_controller #(.HALF_PERIOD(HP7), .CS_GAP(GAP)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .req_valid(r7_valid), .req_ready(r7_ready),
      .req_write(1'b1), .req_addr(7'h00), .req_wdata(8'h00),
      .rsp_valid(r7_rsp_valid), .rsp_rdata(r7_rdata), .busy(r7_busy),
      .nCS(r7_ncs), .SCLK(r7_sclk), .COPI(r7_copi), .CIPO(1'b1)
   );

   always @(posedge r7_sclk) f7 <= {f7[14:0], r7_copi};

   // Peripheral model: 9 registers, invalid addresses read 0, writes commit only on a full 16-bit frame.
   logic [7:0]  regs [0:8] = '{8'h11, 8'h22, 8'h3C, 8'h44, 8'h5E, 8'h66, 8'h77, 8'h81, 8'h90};
   logic [15:0] sh = '0, last_frame = '0;
   logic [7:0]  resp = '0;
   int          edges = 0, frames_done = 0;
   logic        sclk_prev = 1'b0, ncs_prev = 1'b1;

   always @(nCS or SCLK) begin
      if (SCLK === 1'b1 && sclk_prev === 1'b0) begin
         sh = {sh[14:0], COPI};
         edges++;
         if (edges == 8) resp = (sh[6:0] <= MAX_ADDR) ? regs[sh[6:0]] : 8'h00;
      end
      if (SCLK === 1'b0 && sclk_prev === 1'b1 && edges >= 8 && edges < 16)
         CIPO = resp[15-edges];
      if (nCS === 1'b0 && ncs_prev === 1'b1) begin
         edges = 0;
         CIPO  = 1'b0;
      end
      if (nCS === 1'b1 && ncs_prev === 1'b0 && edges == 16) begin
         last_frame = sh;
         frames_done++;
         if (sh[15] == RW_WRITE && sh[14:8] <= MAX_ADDR) regs[sh[14:8]] = sh[7:0];
      end
      sclk_prev = SCLK;
      ncs_prev  = nCS;
   end

   int rsp_cnt = 0;
   always @(posedge clk) rsp_cnt <= rsp_cnt + ((rsp_valid === 1'b1) ? 1 : 0);

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_frame(input logic w, input logic [6:0] a, input logic [7:0] d, input string tag);
      logic [7:0] exp_rd;
      int n, t_rsp, t_rdy, low_cnt, pulses, f0;
      exp_rd = (a <= MAX_ADDR) ? regs[a] : 8'h00;
      f0     = frames_done;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      n = 0;
      while (req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      check_eq({tag, " busy"}, busy, 1);
      check_eq({tag, " copi_msb"}, COPI, w);
      n = 1; t_rsp = 0; t_rdy = 0; pulses = 0;
      low_cnt = (nCS === 1'b0) ? 1 : 0;
      while (t_rdy == 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (nCS === 1'b0) low_cnt++;
         if (rsp_valid === 1'b1) begin
            pulses++;
            if (t_rsp == 0) t_rsp = n;
         end
         if (req_ready === 1'b1) t_rdy = n;
      end
      check_eq({tag, " rsp_lat"}, t_rsp, 1 + FRAME_CYC);
      check_eq({tag, " rdy_lat"}, t_rdy, 1 + FRAME_CYC + GAP);
      check_eq({tag, " ncs_low"}, low_cnt, FRAME_CYC);
      check_eq({tag, " pulses"}, pulses, 1);
      check_eq({tag, " frames"}, frames_done, f0 + 1);
      check_eq({tag, " frame"}, last_frame, pack_frame(w, a, d));
      check_eq({tag, " rdata"}, rsp_rdata, exp_rd);
   endtask

   initial begin
      int n, rdy_hi, hi_cnt, f0, r0, low7;
      logic w;
      logic [6:0] a;
      logic [7:0] d;

      #12;
      check_eq("rst nCS", nCS, 1);
      check_eq("rst SCLK", SCLK, 0);
      check_eq("rst COPI", COPI, 0);
      check_eq("rst ready", req_ready, 1);
      check_eq("rst busy", busy, 0);
      check_eq("rst rsp_valid", rsp_valid, 0);
      check_eq("rst rdata", rsp_rdata, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_frame(1'b1, ADDR_DUTY2, 8'hA5, "t1_wr04");
      run_frame(1'b0, 7'h02, 8'h00, "t2_rd02");
      check_eq("t2 rdata_3c", rsp_rdata, 8'h3C);
      run_frame(1'b1, ADDR_PWM_DIV, 8'h7F, "t3_wr08");
      run_frame(1'b0, ADDR_PWM_DIV, 8'h00, "t3_rd08");
      check_eq("t3 rdata_7f", rsp_rdata, 8'h7F);
      run_frame(1'b1, 7'h09, 8'h55, "t3_wr09");
      run_frame(1'b0, 7'h09, 8'h00, "t3_rd09");
      check_eq("t3 rdata_00", rsp_rdata, 8'h00);

      // Back-to-back: req_valid stays high across two requests.
      f0 = frames_done;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h03; req_wdata = 8'h99;
      @(posedge clk); #1;
      req_write = 1'b0; req_wdata = 8'h00;
      rdy_hi = 0; hi_cnt = 0;
      for (int i = 2; i <= 2 + FRAME_CYC + GAP; i++) begin
         @(posedge clk); #1;
         if (i <= FRAME_CYC + GAP && req_ready === 1'b1) rdy_hi++;
         if (i <= 1 + FRAME_CYC + GAP && nCS === 1'b1) hi_cnt++;
         if (i == 1 + FRAME_CYC + GAP) check_eq("t4 ready_back", req_ready, 1);
         if (i == 2 + FRAME_CYC + GAP) check_eq("t4 second_ncs", nCS, 0);
      end
      req_valid = 1'b0;
      check_eq("t4 ready_low", rdy_hi, 0);
      check_eq("t4 ncs_gap", hi_cnt, GAP + 1);
      n = 0;
      while (req_ready !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
      check_eq("t4 frames", frames_done, f0 + 2);
      check_eq("t4 frame2", last_frame, 16'h0300);
      check_eq("t4 rdata", rsp_rdata, 8'h99);

      // Reset after the 5th SCLK rising edge.
      f0 = frames_done; r0 = rsp_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h01; req_wdata = 8'hEE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (edges < 5 && n < 500) begin @(posedge clk); n++; end
      check_eq("t5 reached_edge5", edges, 5);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5 nCS_async", nCS, 1);
      check_eq("t5 SCLK_async", SCLK, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("t5 ready", req_ready, 1);
      check_eq("t5 no_rsp", rsp_cnt, r0);
      check_eq("t5 no_frame", frames_done, f0);
      run_frame(1'b0, 7'h01, 8'h00, "t5_rd01");
      check_eq("t5 reg1_kept", rsp_rdata, 8'h22);
      run_frame(1'b1, 7'h01, 8'h5A, "t5_wr01");
      run_frame(1'b0, 7'h01, 8'h00, "t5_rd01b");
      check_eq("t5 reg1_new", rsp_rdata, 8'h5A);

      // Random traffic against the peripheral model.
      for (int k = 0; k < 20; k++) begin
         w = 1'($urandom_range(0, 1));
         a = 7'($urandom_range(0, 11));
         d = 8'($urandom);
         run_frame(w, a, d, "rnd");
      end

      // HALF_PERIOD=7 instance, CIPO tied high.
      @(negedge clk);
      r7_valid = 1'b1;
      @(posedge clk); #1;
      r7_valid = 1'b0;
      low7 = (r7_ncs === 1'b0) ? 1 : 0;
      n = 1;
      while (r7_ready !== 1'b1 && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (r7_ncs === 1'b0) low7++;
      end
      check_eq("t6 ncs_low", low7, 33 * HP7);
      check_eq("t6 rdata", r7_rdata, 8'hFF);
      check_eq("t6 frame", f7, 16'h8000);
      check_eq("t6 rdy_lat", n, 1 + 33 * HP7 + GAP);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
